// File: rtl/aes_pkg.sv
// Shared AES constants and word-selection helper, also used by the AHB slave
// address decode.
package aes_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;

    typedef logic [1:0] word_idx_t;

    // Word 0 is the most significant word of the block.
    function automatic logic [AES_WORD_W-1:0] word_sel(
        input logic [AES_BLOCK_W-1:0] blk,
        input word_idx_t              idx
    );
        logic [AES_WORD_W-1:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            2'd3:    w = blk[31:0];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_result_buffer.sv
// Block FIFO between the AES datapath and the bus reader: stores 128-bit
// results and serves them as 32-bit words, MSB word first.
module aes_result_buffer
    import aes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       res_valid,
    input  logic [AES_BLOCK_W-1:0]     res_data,
    output logic                       res_ready,
    input  logic                       rd_en,
    output logic [AES_WORD_W-1:0]      rd_data,
    output logic                       rd_valid,
    input  logic                       clear,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [AES_BLOCK_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0]       rd_ptr_r, rd_ptr_s;
    word_idx_t              idx_r, idx_s;
    logic [CNT_W-1:0]       count_r, count_s;
    logic                   overflow_r, overflow_s;
    logic                   underflow_r, underflow_s;
    logic                   full_s, empty_s, push_s, pop_s, retire_s;

    // Flags come from the registered count only, so a same-cycle retire
    // never opens space for a push.
    assign full_s   = (count_r == CNT_W'(DEPTH));
    assign empty_s  = (count_r == {CNT_W{1'b0}});
    assign push_s   = res_valid && !full_s && !clear;
    assign pop_s    = rd_en && !empty_s && !clear;
    assign retire_s = pop_s && (idx_r == 2'd3);

    // Next-state computation for pointers, word index, count and sticky flags.
    always_comb begin
        wr_ptr_s    = wr_ptr_r;
        rd_ptr_s    = rd_ptr_r;
        idx_s       = idx_r;
        count_s     = count_r;
        overflow_s  = overflow_r;
        underflow_s = underflow_r;
        if (clear) begin
            wr_ptr_s    = {PTR_W{1'b0}};
            rd_ptr_s    = {PTR_W{1'b0}};
            idx_s       = 2'd0;
            count_s     = {CNT_W{1'b0}};
            overflow_s  = 1'b0;
            underflow_s = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (res_valid && full_s) begin
                overflow_s = 1'b1;
            end else begin
                overflow_s = overflow_r;
            end
            if (rd_en && empty_s) begin
                underflow_s = 1'b1;
            end else begin
                underflow_s = underflow_r;
            end
            if (pop_s) begin
                idx_s = idx_r + 2'd1;
            end else begin
                idx_s = idx_r;
            end
            if (retire_s) begin
                rd_ptr_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({push_s, retire_s})
                2'b10:   count_s = count_r + CNT_W'(1);
                2'b01:   count_s = count_r - CNT_W'(1);
                default: count_s = count_r;
            endcase
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            idx_r       <= 2'd0;
            count_r     <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            idx_r       <= idx_s;
            count_r     <= count_s;
            overflow_r  <= overflow_s;
            underflow_r <= underflow_s;
        end
    end

    // Block storage; contents are don't-care until covered by count.
    always_ff @(posedge HCLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= res_data;
        end
    end

    assign res_ready = !full_s;
    assign rd_valid  = !empty_s;
    assign rd_data   = empty_s ? 32'd0 : word_sel(mem_r[rd_ptr_r], idx_r);
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule
